// File: rtl/pts_pkg.sv
// Shared types and default sizing for the parallel-to-serial transmitter.
package pts_pkg;

  localparam int DEF_WIDTH    = 9;
  localparam int DEF_CNT_BITS = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pts_bit_counter.sv
// Frame bit counter: synchronous clear has priority over increment.
module pts_bit_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                inc,
  output logic [CNT_BITS-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/parallel_to_serial_wrapper.sv
// MSB-first parallel-to-serial transmitter for an SD DAT/CMD line.
// Define PTS_TRISTATE_EN to release serial (1'bz) whenever no frame is being sent.
module parallel_to_serial_wrapper
  import pts_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [CNT_BITS-1:0] framesize,
  input  logic                load_send,
  input  logic [WIDTH-1:0]    parallel,
  output logic                serial,
  output logic                complete
);

  state_t              state;
  state_t              state_nxt;
  logic [WIDTH-1:0]    shreg;
  logic [CNT_BITS-1:0] cnt;
  logic                cnt_clr;
  logic                cnt_inc;
  logic                load;
  logic                last_bit;

  assign last_bit = (cnt == (framesize - 1'b1));

  pts_bit_counter #(
    .CNT_BITS(CNT_BITS)
  ) u_bit_counter (
    .clk  (Clock),
    .rst_n(Reset),
    .clear(cnt_clr),
    .inc  (cnt_inc),
    .count(cnt)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    load      = 1'b0;
    unique case (state)
      IDLE: begin
        if (Enable && load_send) begin
          load      = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = (framesize == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (!Enable) begin
          state_nxt = IDLE;
        end else begin
          cnt_inc = 1'b1;
          if (last_bit) state_nxt = DONE;
        end
      end
      DONE: begin
        // Wait for load_send to drop so a held request sends only one frame.
        if (!load_send || !Enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Ones shift in behind the data so frames longer than WIDTH pad with 1s.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      shreg <= '1;
    end else if (load) begin
      shreg <= parallel;
    end else if (state == SEND) begin
      shreg <= {shreg[WIDTH-2:0], 1'b1};
    end
  end

  assign complete = (state == DONE);

`ifdef PTS_TRISTATE_EN
  assign serial = (state == SEND) ? shreg[WIDTH-1] : 1'bz;
`else
  assign serial = (state == SEND) ? shreg[WIDTH-1] : 1'b1;
`endif

endmodule

// File: tb/tb_parallel_to_serial_wrapper.sv
// Scoreboard bench for parallel_to_serial_wrapper: expected bits are queued per frame.
module tb_parallel_to_serial_wrapper;

  localparam int WIDTH    = 9;
  localparam int CNT_BITS = 8;

  logic                Clock = 1'b0;
  logic                Reset;
  logic                Enable;
  logic [CNT_BITS-1:0] framesize;
  logic                load_send;
  logic [WIDTH-1:0]    parallel;
  logic                serial;
  logic                complete;

  logic idle_lvl;
  logic exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  parallel_to_serial_wrapper #(
    .WIDTH   (WIDTH),
    .CNT_BITS(CNT_BITS)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Enable   (Enable),
    .framesize(framesize),
    .load_send(load_send),
    .parallel (parallel),
    .serial   (serial),
    .complete (complete)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_serial"}, {31'd0, serial}, {31'd0, idle_lvl});
    check({tag, "_complete"}, {31'd0, complete}, 32'd0);
  endtask

  // Queue the reference bit stream and issue the load request.
  task automatic start_frame(input logic [WIDTH-1:0] p, input int fs, input bit hold);
    for (int k = 0; k < fs; k++) begin
      if (k < WIDTH) exp_q.push_back(p[WIDTH-1-k]);
      else           exp_q.push_back(1'b1);
    end
    parallel  = p;
    framesize = CNT_BITS'(fs);
    load_send = 1'b1;
    step();
    if (!hold) load_send = 1'b0;
  endtask

  task automatic check_bits(input string tag, input int n);
    logic e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) begin
        check({tag, "_underflow"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({tag, "_bit"}, {31'd0, serial}, {31'd0, e});
        check({tag, "_cmpl_low"}, {31'd0, complete}, 32'd0);
      end
      parallel = WIDTH'($urandom);
      step();
    end
  endtask

  initial begin
`ifdef PTS_TRISTATE_EN
    idle_lvl = 1'bz;
`else
    idle_lvl = 1'b1;
`endif
    Reset = 1'b0; Enable = 1'b0; load_send = 1'b0;
    framesize = '0; parallel = '0;
    #1;

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      check_idle("reset");
      step();
    end
    Reset = 1'b1;
    Enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_idle("post_reset");
      step();
    end

    // Basic 9-bit frame: 1,1,1,0,0,1,0,1,1
    start_frame(9'b1_1100_1011, 9, 1'b0);
    check_bits("basic", 9);
    check("basic_complete", {31'd0, complete}, 32'd1);
    check("basic_done_serial", {31'd0, serial}, {31'd0, idle_lvl});
    step();
    check_idle("basic_back_idle");

    // load_send held for 36 edges: one frame only
    start_frame(9'b1_1100_1011, 9, 1'b1);
    check_bits("held", 9);
    for (int i = 0; i < 26; i++) begin
      check("held_complete", {31'd0, complete}, 32'd1);
      check("held_serial", {31'd0, serial}, {31'd0, idle_lvl});
      step();
    end
    load_send = 1'b0;
    check("held_complete_last", {31'd0, complete}, 32'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      check_idle("held_release");
      step();
    end

    // Enable dropped at bit 4
    start_frame(9'h000, 9, 1'b0);
    check_bits("abort", 4);
    Enable = 1'b0;
    check_bits("abort", 1);
    exp_q.delete();
    for (int i = 0; i < 12; i++) begin
      check_idle("abort_idle");
      step();
    end
    Enable = 1'b1;

    // framesize beyond WIDTH pads with ones
    start_frame(9'h000, 12, 1'b0);
    check_bits("long", 12);
    check("long_complete", {31'd0, complete}, 32'd1);
    step();
    check_idle("long_back_idle");

    // framesize zero goes straight to DONE
    start_frame(9'h0F0, 0, 1'b0);
    check("zero_complete", {31'd0, complete}, 32'd1);
    check("zero_serial", {31'd0, serial}, {31'd0, idle_lvl});
    step();
    check_idle("zero_back_idle");

    // Reset mid-frame, then a fresh frame
    start_frame(9'h000, 9, 1'b0);
    check_bits("midrst", 3);
    #2;
    Reset = 1'b0;
    #1;
    check_idle("midrst_async");
    exp_q.delete();
    step();
    Reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_idle("midrst_wait");
      step();
    end
    start_frame(9'h0A5, 9, 1'b0);
    check_bits("after_rst", 9);
    check("after_rst_complete", {31'd0, complete}, 32'd1);
    step();
    check_idle("after_rst_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parallel_to_serial_wrapper.md
PARALLEL_TO_SERIAL_WRAPPER -- requirements
Module: parallel_to_serial_wrapper

Interface
REQ-001 SHALL have parameter WIDTH, default 9, meaning the parallel word width in bits.
REQ-002 SHALL have parameter CNT_BITS, default 8, meaning the width of framesize and of the internal bit counter.
REQ-003 SHALL have port Clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port Reset, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port Enable, input, 1, meaning transmitter enable; low aborts or blocks transmission.
REQ-006 SHALL have port framesize, input, CNT_BITS, meaning the number of bits to send per frame.
REQ-007 SHALL have port load_send, input, 1, meaning a request to load parallel and transmit it.
REQ-008 SHALL have port parallel, input, WIDTH, meaning the word to transmit, MSB first.
REQ-009 SHALL have port serial, output, 1, meaning the serial bit stream (SD DAT/CMD line).
REQ-010 SHALL have port complete, output, 1, meaning the frame has been fully sent.

Function
REQ-011 SHALL implement FSM states IDLE, SEND and DONE.
REQ-012 In IDLE, a rising edge with Enable=1 and load_send=1 SHALL capture parallel into the shift register, clear the counter and move to SEND.
REQ-013 In SEND, serial SHALL equal the shift register MSB; each clock SHALL shift left, filling the LSB with 1, and increment the counter.
REQ-014 Bit k (k=0..framesize-1) of the frame SHALL appear on serial during the k-th SEND cycle, equal to parallel[WIDTH-1-k].
REQ-015 For framesize > WIDTH, the bits beyond WIDTH SHALL be 1.
REQ-016 When the counter reaches framesize-1 in SEND, the next state SHALL be DONE, so the frame occupies exactly framesize cycles.
REQ-017 framesize=0 SHALL move IDLE directly to DONE and send no bits.
REQ-018 In DONE, complete SHALL be 1 and serial SHALL be at idle level; complete SHALL be 0 in all other states.
REQ-019 DONE SHALL return to IDLE when load_send=0 or Enable=0, so a held load_send never retransmits.
REQ-020 Enable=0 during SEND SHALL abort to IDLE on the next edge without asserting complete.
REQ-021 load_send and parallel changes during SEND SHALL be ignored.
REQ-022 In IDLE, serial SHALL be at idle level, which is 1 unless REQ-026 applies.

Reset
REQ-023 Reset=0 SHALL asynchronously force state IDLE, shift register to all-ones, counter to 0, complete to 0 and serial to idle level.
REQ-024 Reset asserted mid-frame SHALL discard the frame; after release a new load_send SHALL be required.

Configuration
REQ-025 SHALL support the macro PTS_TRISTATE_EN.
REQ-026 With PTS_TRISTATE_EN defined, serial SHALL be 1'bz in IDLE, DONE and reset, and SHALL be driven only in SEND, for a shared bus.
REQ-027 Without PTS_TRISTATE_EN, serial SHALL drive 1 whenever it is not in SEND.

Structure
REQ-028 A shared package pts_pkg SHALL hold the state enum (IDLE/SEND/DONE) and default constants (WIDTH=9, CNT_BITS=8).
REQ-029 The bit counter SHALL be a sub-module pts_bit_counter with clear, increment enable and a CNT_BITS count output; the shift register and FSM SHALL stay in the top.

Verification
REQ-030 Reset low for 3 cycles, then released: serial=1 (or z with the macro) and complete=0 immediately and throughout.
REQ-031 parallel=9'b1_1100_1011, framesize=9, Enable=1, load_send pulsed: serial over 9 cycles = 1,1,1,0,0,1,0,1,1; complete=1 on cycle 10.
REQ-032 load_send held high for 36 cycles in the REQ-031 setup: exactly one frame is sent and complete stays 1 until load_send falls, then the FSM returns to IDLE.
REQ-033 Enable dropped at bit 4 of a 9-bit frame: the FSM returns to IDLE, complete never asserts and serial returns to idle level.
REQ-034 framesize=12, parallel=9'h000: serial = nine 0s then three 1s; complete asserts after 12 cycles.
REQ-035 Reset pulsed mid-frame, then a new load_send: serial goes to idle level asynchronously and the new frame transmits fully from bit 0.
